// File: rtl/rvfi_commit_sequencer.sv
// In-order commit sequencer: allocates slots in program order, accepts completions by tag and
// retires one done slot per cycle onto RVFI fields. Optional macro RVFI_SEQ_TIMEOUT_EN adds a head watchdog.
module rvfi_commit_sequencer #(
    parameter int DEPTH          = 16,
    parameter int TAG_W          = $clog2(DEPTH),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [31:0]      alloc_pc,
    input  logic [31:0]      alloc_inst,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cmp_valid,
    input  logic [TAG_W-1:0] cmp_tag,
    input  logic [4:0]       cmp_rd_addr,
    input  logic [31:0]      cmp_rd_wdata,
    input  logic [31:0]      cmp_pc_wdata,
    input  logic             flush,
    output logic             valid,
    output logic [63:0]      order,
    output logic [31:0]      inst,
    output logic [31:0]      pc_rdata,
    output logic [31:0]      pc_wdata,
    output logic [4:0]       rd_addr,
    output logic [31:0]      rd_wdata,
    output logic             halt,
    output logic             error
);

    localparam int CNT_W = TAG_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("rvfi_commit_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [DEPTH-1:0] slot_alloc_q, slot_alloc_d;
    logic [DEPTH-1:0] slot_done_q, slot_done_d;
    logic [31:0]      slot_pc_q [DEPTH];
    logic [31:0]      slot_pc_d [DEPTH];
    logic [31:0]      slot_inst_q [DEPTH];
    logic [31:0]      slot_inst_d [DEPTH];
    logic [4:0]       slot_rd_addr_q [DEPTH];
    logic [4:0]       slot_rd_addr_d [DEPTH];
    logic [31:0]      slot_rd_wdata_q [DEPTH];
    logic [31:0]      slot_rd_wdata_d [DEPTH];
    logic [31:0]      slot_pc_wdata_q [DEPTH];
    logic [31:0]      slot_pc_wdata_d [DEPTH];

    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      order_cnt_q, order_cnt_d;

    logic             valid_q, valid_d;
    logic [63:0]      order_q, order_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      pc_rdata_q, pc_rdata_d;
    logic [31:0]      pc_wdata_q, pc_wdata_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [31:0]      rd_wdata_q, rd_wdata_d;
    logic             halt_q, halt_d;
    logic             error_q, error_d;

    logic             alloc_fire, retire, cmp_hit, cmp_ok, cmp_bad;
    logic             timeout_fire;

    assign alloc_ready = (count_q != CNT_W'(DEPTH)) && !flush && !halt_q;
    assign alloc_tag   = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign retire      = slot_alloc_q[head_q] && slot_done_q[head_q] && !halt_q;
    assign cmp_hit     = cmp_valid && !flush;
    assign cmp_ok      = cmp_hit && slot_alloc_q[cmp_tag] && !slot_done_q[cmp_tag];
    assign cmp_bad     = cmp_hit && !cmp_ok;

    // Slot bookkeeping; flush applies last so it wins over alloc/completion in the same cycle.
    always_comb begin
        slot_alloc_d    = slot_alloc_q;
        slot_done_d     = slot_done_q;
        slot_pc_d       = slot_pc_q;
        slot_inst_d     = slot_inst_q;
        slot_rd_addr_d  = slot_rd_addr_q;
        slot_rd_wdata_d = slot_rd_wdata_q;
        slot_pc_wdata_d = slot_pc_wdata_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;

        if (cmp_ok) begin
            slot_done_d[cmp_tag]     = 1'b1;
            slot_rd_addr_d[cmp_tag]  = cmp_rd_addr;
            slot_rd_wdata_d[cmp_tag] = cmp_rd_wdata;
            slot_pc_wdata_d[cmp_tag] = cmp_pc_wdata;
        end
        if (alloc_fire) begin
            slot_alloc_d[tail_q] = 1'b1;
            slot_done_d[tail_q]  = 1'b0;
            slot_pc_d[tail_q]    = alloc_pc;
            slot_inst_d[tail_q]  = alloc_inst;
            tail_d               = tail_q + TAG_W'(1);
        end
        if (retire) begin
            slot_alloc_d[head_q] = 1'b0;
            slot_done_d[head_q]  = 1'b0;
            head_d               = head_q + TAG_W'(1);
        end
        case ({alloc_fire, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            slot_alloc_d = '0;
            slot_done_d  = '0;
            tail_d       = head_d;
            count_d      = '0;
        end
    end

    always_comb begin
        valid_d     = retire;
        order_d     = order_q;
        order_cnt_d = order_cnt_q;
        inst_d      = inst_q;
        pc_rdata_d  = pc_rdata_q;
        pc_wdata_d  = pc_wdata_q;
        rd_addr_d   = rd_addr_q;
        rd_wdata_d  = rd_wdata_q;
        halt_d      = halt_q;
        error_d     = error_q || cmp_bad || timeout_fire;
        if (retire) begin
            order_d     = order_cnt_q;
            order_cnt_d = order_cnt_q + 64'd1;
            inst_d      = slot_inst_q[head_q];
            pc_rdata_d  = slot_pc_q[head_q];
            pc_wdata_d  = slot_pc_wdata_q[head_q];
            rd_addr_d   = slot_rd_addr_q[head_q];
            rd_wdata_d  = (slot_rd_addr_q[head_q] == 5'd0) ? 32'd0 : slot_rd_wdata_q[head_q];
            if (slot_pc_q[head_q] == slot_pc_wdata_q[head_q]) halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_alloc_q <= '0;
            slot_done_q  <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            order_cnt_q  <= '0;
            valid_q      <= 1'b0;
            order_q      <= '0;
            inst_q       <= '0;
            pc_rdata_q   <= '0;
            pc_wdata_q   <= '0;
            rd_addr_q    <= '0;
            rd_wdata_q   <= '0;
            halt_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            slot_alloc_q <= slot_alloc_d;
            slot_done_q  <= slot_done_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            order_cnt_q  <= order_cnt_d;
            valid_q      <= valid_d;
            order_q      <= order_d;
            inst_q       <= inst_d;
            pc_rdata_q   <= pc_rdata_d;
            pc_wdata_q   <= pc_wdata_d;
            rd_addr_q    <= rd_addr_d;
            rd_wdata_q   <= rd_wdata_d;
            halt_q       <= halt_d;
            error_q      <= error_d;
        end
    end

    // Payload storage is qualified by the alloc/done bits, so it needs no reset.
    always_ff @(posedge clk) begin
        slot_pc_q       <= slot_pc_d;
        slot_inst_q     <= slot_inst_d;
        slot_rd_addr_q  <= slot_rd_addr_d;
        slot_rd_wdata_q <= slot_rd_wdata_d;
        slot_pc_wdata_q <= slot_pc_wdata_d;
    end

`ifdef RVFI_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_left_q, to_left_d;
    logic            head_pending;

    assign head_pending = slot_alloc_q[head_q] && !slot_done_q[head_q];

    // Down-counter from TIMEOUT_CYCLES; reaching zero while the head is stuck raises error.
    always_comb begin
        to_left_d    = to_left_q;
        timeout_fire = 1'b0;
        if (retire || flush) begin
            to_left_d = TO_W'(TIMEOUT_CYCLES);
        end else if (head_pending && to_left_q != '0) begin
            to_left_d    = to_left_q - TO_W'(1);
            timeout_fire = (to_left_q == TO_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) to_left_q <= TO_W'(TIMEOUT_CYCLES);
        else     to_left_q <= to_left_d;
    end

    always_ff @(posedge clk) begin
        if (!rst && timeout_fire) $error("commit timeout");
    end
`else
    assign timeout_fire = 1'b0;
`endif

    assign valid    = valid_q;
    assign order    = order_q;
    assign inst     = inst_q;
    assign pc_rdata = pc_rdata_q;
    assign pc_wdata = pc_wdata_q;
    assign rd_addr  = rd_addr_q;
    assign rd_wdata = rd_wdata_q;
    assign halt     = halt_q;
    assign error    = error_q;

endmodule
